tower_topk_sorter: RTL
======================

# tower_topk_sorter

Streaming top-K selector for calorimeter towers. Accepts one tower (eta, phi, ET) per cycle for an event, keeps a sorted list of the K highest-ET towers, and on end-of-event emits them in rank order over a valid/ready output. It sits after the tower readout and feeds jet seeding. It generalises single-maximum ET search to a configurable K, field widths and a streaming handshake.

## Interface
Parameters:
- `ET_W`, default 8: tower ET width, unsigned.
- `ETA_W`, default 6: eta index width.
- `PHI_W`, default 6: phi index width.
- `K`, default 4: number of ranked slots, 2..16.
- `ET_THRESH`, default 0: minimum ET accepted. Used only with `TOPK_ET_THRESHOLD_EN`.

Ports (`RK_W` = $clog2(K)):
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input tower present.
- `in_ready`  out  1  block accepts a tower this cycle.
- `in_et`  in  ET_W  tower ET.
- `in_eta`  in  ETA_W  tower eta.
- `in_phi`  in  PHI_W  tower phi.
- `in_last`  in  1  final tower of the event.
- `out_valid`  out  1  ranked entry present.
- `out_ready`  in  1  downstream accepts the entry.
- `out_et`, `out_eta`, `out_phi`  out  ET_W/ETA_W/PHI_W  ranked tower fields.
- `out_rank`  out  RK_W  slot index; 0 = highest ET.
- `out_hit`  out  1  slot holds a real tower. When 0, fields read 0.
- `out_last`  out  1  asserted with rank K-1.

## Operation
- Storage: K slots of {hit, et, eta, phi}, kept sorted by descending ET. Hit slots always precede empty ones.
- States:
  - COLLECT (reset state): `in_ready`=1.
  - DRAIN: `in_ready`=0.
- Insertion happens on an accepted beat (`in_valid && in_ready`) in COLLECT:
  - Insert position p = number of hit slots with `et >= in_et`. Ties keep arrival order: the earlier tower ranks higher.
  - Slots p..K-2 shift down one place, the new tower is written into slot p, and the old slot K-1 is dropped.
  - If p == K, the tower is discarded.
  - The whole insertion takes one cycle, so back-to-back beats are sustained at one per cycle.
- An accepted beat with `in_last`=1 is inserted normally, then the state moves to DRAIN and the rank counter is cleared to 0.
- DRAIN:
  - `out_valid`=1 and the outputs present the slot at `rank`.
  - Each `out_valid && out_ready` increments `rank`.
  - The handshake on rank K-1 (`out_last`=1) clears every slot's hit bit and returns the state to COLLECT.
- Exactly K output beats are produced per event, regardless of how many towers arrived.
- ET is compared as unsigned. There is no accumulation, so no overflow.

## Timing
- Reset values:
  - `in_ready`=1 once `rst_n` deasserts.
  - `out_valid`=0; `out_rank`=0; `out_hit`=0; `out_last`=0; all field outputs 0.
  - All slots empty; state COLLECT.
- Latency: `out_valid` rises on the cycle after the edge that accepted `in_last`.
- Outputs are registered and held stable while `out_valid && !out_ready`.
- Turnaround: `in_ready` rises on the cycle after the rank K-1 handshake. Minimum event period is N + K cycles for N towers.
- `in_*` are ignored in DRAIN, including `in_valid`=1 held high.
- A single-tower event (`in_last` on the first beat): rank 0 carries `out_hit`=1, ranks 1..K-1 carry `out_hit`=0.
- Reset mid-event or mid-drain: immediately empties all slots, returns to COLLECT and drops `out_valid`. There is no partial output.

## Configuration
- `TOPK_ET_THRESHOLD_EN` defined:
  - A beat with `in_et < ET_THRESH` is consumed (handshake completes) but not inserted.
  - Its `in_last` still ends the event; an event with every tower below threshold drains K beats with `out_hit`=0.
- Not defined: every tower is a candidate and `ET_THRESH` has no effect.

## Test plan
- K=4, ETs 5, 9, 3, 9, 7, last on the fifth tower, `out_ready`=1:
  - outputs ET 9 (first), 9 (second), 7, 5; `out_hit`=1 on all four; `out_last` only at rank 3; first `out_valid` one cycle after last.
- K=4, two towers ET 12, 4: ranks 0..1 = 12, 4 with hit=1; ranks 2..3 have hit=0, fields 0.
- Backpressure: `out_ready` toggles 1,0,0,1 during drain → each rank held stable until accepted. `in_ready`=0 throughout drain with `in_valid`=1 driven; no insertion occurs.
- `rst_n` pulsed low after rank 1 is drained → `out_valid`=0 asynchronously. The next event of ET 1, last, produces rank 0 = 1 with ranks 1..3 empty.
- With `TOPK_ET_THRESHOLD_EN`, `ET_THRESH`=10, ETs 8, 15, 10, 2, last:
  - outputs 15, 10, then two hit=0 beats.
  - Without the macro, the same stimulus gives 15, 10, 8, 2.

Source files
------------

// File: rtl/tower_topk_sorter.sv
// Streaming top-K tower selector: keeps K highest-ET towers sorted, drains them in rank order.
// Optional macro TOPK_ET_THRESHOLD_EN: towers below ET_THRESH are consumed but not inserted.
module tower_topk_sorter #(
  parameter int unsigned ET_W      = 8,
  parameter int unsigned ETA_W     = 6,
  parameter int unsigned PHI_W     = 6,
  parameter int unsigned K         = 4,
  parameter int unsigned ET_THRESH = 0,
  localparam int unsigned RK_W     = $clog2(K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ET_W-1:0]  in_et,
  input  logic [ETA_W-1:0] in_eta,
  input  logic [PHI_W-1:0] in_phi,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ET_W-1:0]  out_et,
  output logic [ETA_W-1:0] out_eta,
  output logic [PHI_W-1:0] out_phi,
  output logic [RK_W-1:0]  out_rank,
  output logic             out_hit,
  output logic             out_last
);

  typedef enum logic {COLLECT, DRAIN} state_t;

`ifdef TOPK_ET_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [RK_W-1:0]  rank_q, rank_d;
  logic             hit_q [K];
  logic             hit_d [K];
  logic [ET_W-1:0]  et_q  [K];
  logic [ET_W-1:0]  et_d  [K];
  logic [ETA_W-1:0] eta_q [K];
  logic [ETA_W-1:0] eta_d [K];
  logic [PHI_W-1:0] phi_q [K];
  logic [PHI_W-1:0] phi_d [K];

  logic [ET_W-1:0] thr;
  logic            accept, candidate, show;
  logic [K-1:0]    ge, ge_prev;

  assign thr       = ET_W'(ET_THRESH);
  assign accept    = in_valid && in_ready;
  assign candidate = !(THR_EN && (in_et < thr));

  // ge is a prefix mask (hit slots first, descending ET), so insert slot p
  // is the first index where ge drops, and slots past p shift down.
  always_comb begin
    for (int unsigned i = 0; i < K; i++) begin
      ge[i] = hit_q[i] && (et_q[i] >= in_et);
    end
    ge_prev = {ge[K-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    for (int unsigned i = 0; i < K; i++) begin
      hit_d[i] = hit_q[i];
      et_d[i]  = et_q[i];
      eta_d[i] = eta_q[i];
      phi_d[i] = phi_q[i];
    end
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (candidate) begin
            for (int unsigned i = 1; i < K; i++) begin
              if (!ge_prev[i]) begin
                hit_d[i] = hit_q[i-1];
                et_d[i]  = et_q[i-1];
                eta_d[i] = eta_q[i-1];
                phi_d[i] = phi_q[i-1];
              end
            end
            for (int unsigned i = 0; i < K; i++) begin
              if (!ge[i] && ge_prev[i]) begin
                hit_d[i] = 1'b1;
                et_d[i]  = in_et;
                eta_d[i] = in_eta;
                phi_d[i] = in_phi;
              end
            end
          end
          if (in_last) begin
            state_d = DRAIN;
            rank_d  = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rank_q == RK_W'(K - 1)) begin
            state_d = COLLECT;
            rank_d  = '0;
            for (int unsigned i = 0; i < K; i++) begin
              hit_d[i] = 1'b0;
            end
          end else begin
            rank_d = rank_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      rank_q  <= '0;
      for (int unsigned i = 0; i < K; i++) begin
        hit_q[i] <= 1'b0;
        et_q[i]  <= '0;
        eta_q[i] <= '0;
        phi_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rank_q  <= rank_d;
      for (int unsigned i = 0; i < K; i++) begin
        hit_q[i] <= hit_d[i];
        et_q[i]  <= et_d[i];
        eta_q[i] <= eta_d[i];
        phi_q[i] <= phi_d[i];
      end
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == DRAIN);
  assign show      = out_valid && hit_q[rank_q];
  assign out_hit   = show;
  assign out_rank  = rank_q;
  assign out_last  = out_valid && (rank_q == RK_W'(K - 1));
  assign out_et    = show ? et_q[rank_q]  : '0;
  assign out_eta   = show ? eta_q[rank_q] : '0;
  assign out_phi   = show ? phi_q[rank_q] : '0;

endmodule
